// File: rtl/nw_pkg.sv
// Shared definitions for the NW aligner: nucleotide ASCII codes, the
// sequence-buffer state encoding and the character normalisation used by loader and scorer.
package nw_pkg;

   typedef logic [7:0] char_t;

   localparam char_t CH_A = 8'h41;
   localparam char_t CH_C = 8'h43;
   localparam char_t CH_G = 8'h47;
   localparam char_t CH_T = 8'h54;
   localparam char_t CH_N = 8'h4E;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } state_t;

   typedef struct packed {
      logic  invalid;
      char_t ch;
   } norm_t;

   // Upper-cases ACGT; anything else becomes N and is flagged.
   function automatic norm_t norm_char(input char_t c);
      norm_t r;
      r.invalid = 1'b0;
      case (c)
         8'h41, 8'h61: r.ch = CH_A;
         8'h43, 8'h63: r.ch = CH_C;
         8'h47, 8'h67: r.ch = CH_G;
         8'h54, 8'h74: r.ch = CH_T;
         default: begin
            r.ch      = CH_N;
            r.invalid = 1'b1;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seq_buffer_if.sv
// Character load stream into a sequence buffer: framing pulses plus a
// valid/ready data channel.
interface seq_buffer_if;
   import nw_pkg::*;

   logic  load_start;
   char_t din;
   logic  din_valid;
   logic  din_ready;
   logic  load_done;

   modport master (output load_start, din, din_valid, load_done, input din_ready);
   modport slave  (input load_start, din, din_valid, load_done, output din_ready);

endinterface

// File: rtl/seq_mem_2r1w.sv
// DEPTH x 8 character store: one synchronous write port, two independent
// synchronous read ports whose output registers hold while disabled.
module seq_mem_2r1w
   import nw_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  char_t         i_wdata,
   input  logic          i_re_a,
   input  logic [AW-1:0] i_raddr_a,
   output char_t         o_rdata_a,
   input  logic          i_re_b,
   input  logic [AW-1:0] i_raddr_b,
   output char_t         o_rdata_b
);

   char_t r_mem [DEPTH];
   char_t r_rdata_a;
   char_t r_rdata_b;

   // NOTE: the array has no reset so it maps onto RAM; validity is tracked by the owner.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata_a <= '0;
         r_rdata_b <= '0;
      end else begin
         if (i_re_a) r_rdata_a <= r_mem[i_raddr_a];
         if (i_re_b) r_rdata_b <= r_mem[i_raddr_b];
      end
   end

   assign o_rdata_a = r_rdata_a;
   assign o_rdata_b = r_rdata_b;

endmodule

// File: rtl/seq_buffer.sv
// Sequence store for the NW aligner: loads and normalises one sequence,
// records its length and serves two registered, bounds-checked read ports.
module seq_buffer
   import nw_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH),
   parameter int LW    = $clog2(DEPTH+1)
) (
   input  logic          clk,
   input  logic          rst,
   seq_buffer_if.slave   load_if,
   output logic          ready,
   output logic [LW-1:0] len,
   output logic          err_char,
   output logic          overflow,
   input  logic          rd_en_a,
   input  logic [AW-1:0] rd_addr_a,
   output char_t         rd_data_a,
   output logic          rd_oob_a,
   input  logic          rd_en_b,
   input  logic [AW-1:0] rd_addr_b,
   output char_t         rd_data_b,
   output logic          rd_oob_b
);

   state_t        r_state;
   state_t        w_next;
   logic [LW-1:0] r_wptr;
   logic [LW-1:0] r_len;
   logic          r_err;
   logic          r_ovf;
   logic          r_oob_a;
   logic          r_oob_b;
   logic          w_full;
   logic          w_din_ready;
   logic          w_ready;
   logic          w_accept;
   logic          w_oob_a;
   logic          w_oob_b;
   norm_t         w_norm;
   char_t         w_q_a;
   char_t         w_q_b;

   assign w_full   = (r_wptr == LW'(DEPTH));
   assign w_accept = load_if.din_valid & w_din_ready;
   assign w_norm   = norm_char(load_if.din);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_next      = r_state;
      w_din_ready = 1'b0;
      w_ready     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load_if.load_start) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            w_din_ready = ~w_full;
            if (load_if.load_start)     w_next = ST_LOAD;
            else if (load_if.load_done) w_next = ST_READY;
         end
         ST_READY: begin
            w_ready = 1'b1;
            if (load_if.load_start) w_next = ST_LOAD;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next;
   end

   // load_start wins over load_done and any write in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_len  <= '0;
         r_err  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (load_if.load_start) begin
         r_wptr <= '0;
         r_len  <= '0;
         r_err  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (r_state == ST_LOAD) begin
         if (w_accept) begin
            r_wptr <= r_wptr + LW'(1);
            if (w_norm.invalid) r_err <= 1'b1;
         end
         if (load_if.din_valid && w_full) r_ovf <= 1'b1;
         if (load_if.load_done)           r_len <= r_wptr + LW'(w_accept);
      end
   end

   // Reads outside READY are always oob, which hides any read-during-write.
   assign w_oob_a = (r_state != ST_READY) || (LW'(rd_addr_a) >= r_len);
   assign w_oob_b = (r_state != ST_READY) || (LW'(rd_addr_b) >= r_len);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_oob_a <= 1'b0;
         r_oob_b <= 1'b0;
      end else begin
         if (rd_en_a) r_oob_a <= w_oob_a;
         if (rd_en_b) r_oob_b <= w_oob_b;
      end
   end

   seq_mem_2r1w #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_accept),
      .i_waddr   (r_wptr[AW-1:0]),
      .i_wdata   (w_norm.ch),
      .i_re_a    (rd_en_a),
      .i_raddr_a (rd_addr_a),
      .o_rdata_a (w_q_a),
      .i_re_b    (rd_en_b),
      .i_raddr_b (rd_addr_b),
      .o_rdata_b (w_q_b)
   );

   assign load_if.din_ready = w_din_ready;
   assign ready             = w_ready;
   assign len               = r_len;
   assign err_char          = r_err;
   assign overflow          = r_ovf;
   assign rd_oob_a          = r_oob_a;
   assign rd_oob_b          = r_oob_b;
   assign rd_data_a         = r_oob_a ? '0 : w_q_a;
   assign rd_data_b         = r_oob_b ? '0 : w_q_b;

endmodule

// File: tb/tb_seq_buffer.sv
// Bench for seq_buffer: a DEPTH=128 instance for loading/reading and a
// DEPTH=4 instance for the full/overflow boundary.
module tb_seq_buffer;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   seq_buffer_if sif ();
   seq_buffer_if sif4 ();

   logic       ready, err_char, overflow;
   logic [7:0] len;
   logic       rd_en_a = 0, rd_en_b = 0;
   logic [6:0] rd_addr_a = 0, rd_addr_b = 0;
   logic [7:0] rd_data_a, rd_data_b;
   logic       rd_oob_a, rd_oob_b;

   logic       ready4, err4, ovf4;
   logic [2:0] len4;
   logic       rd_en_a4 = 0, rd_en_b4 = 0;
   logic [1:0] rd_addr_a4 = 0, rd_addr_b4 = 0;
   logic [7:0] rd_data_a4, rd_data_b4;
   logic       rd_oob_a4, rd_oob_b4;

   seq_buffer u_dut (
      .clk(clk), .rst(rst_n), .load_if(sif),
      .ready(ready), .len(len), .err_char(err_char), .overflow(overflow),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_oob_a(rd_oob_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_oob_b(rd_oob_b)
   );

   seq_buffer #(.DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst_n), .load_if(sif4),
      .ready(ready4), .len(len4), .err_char(err4), .overflow(ovf4),
      .rd_en_a(rd_en_a4), .rd_addr_a(rd_addr_a4), .rd_data_a(rd_data_a4), .rd_oob_a(rd_oob_a4),
      .rd_en_b(rd_en_b4), .rd_addr_b(rd_addr_b4), .rd_data_b(rd_data_b4), .rd_oob_b(rd_oob_b4)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model of the stored sequence and read scoreboard ({oob, data}).
   logic [7:0] model [128];
   int         m_wp = 0;
   int         m_len = 0;
   bit         m_ready = 0;
   logic [8:0] q_a [$];
   logic [8:0] q_b [$];
   logic [8:0] last_a, last_b;

   function automatic logic [7:0] tb_norm(input logic [7:0] c);
      case (c)
         "A", "a": return 8'h41;
         "C", "c": return 8'h43;
         "G", "g": return 8'h47;
         "T", "t": return 8'h54;
         default:  return 8'h4E;
      endcase
   endfunction

   function automatic logic [8:0] expect_rd(input logic [6:0] addr);
      if (!m_ready || int'(addr) >= m_len) return {1'b1, 8'h00};
      return {1'b0, model[addr]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      sif.load_start = 1'b1;
      tick();
      sif.load_start = 1'b0;
      m_wp = 0; m_len = 0; m_ready = 0;
   endtask

   task automatic pulse_done();
      sif.load_done = 1'b1;
      tick();
      sif.load_done = 1'b0;
      m_len = m_wp; m_ready = 1;
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         sif.din = s[i];
         sif.din_valid = 1'b1;
         tick();
         model[m_wp] = tb_norm(s[i]);
         m_wp++;
      end
      sif.din_valid = 1'b0;
   endtask

   task automatic rd(input bit ea, input logic [6:0] aa, input bit eb, input logic [6:0] ab);
      logic [8:0] e;
      rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
      if (ea) q_a.push_back(expect_rd(aa));
      if (eb) q_b.push_back(expect_rd(ab));
      tick();
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      while (q_a.size() > 0) begin
         e = q_a.pop_front();
         n_vec++;
         if ({rd_oob_a, rd_data_a} !== e) begin
            n_err++;
            $display("FAIL rd_a addr=%0d got oob=%b data=%h want oob=%b data=%h", aa, rd_oob_a, rd_data_a, e[8], e[7:0]);
         end
         last_a = e;
      end
      while (q_b.size() > 0) begin
         e = q_b.pop_front();
         n_vec++;
         if ({rd_oob_b, rd_data_b} !== e) begin
            n_err++;
            $display("FAIL rd_b addr=%0d got oob=%b data=%h want oob=%b data=%h", ab, rd_oob_b, rd_data_b, e[8], e[7:0]);
         end
         last_b = e;
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      n_vec++;
      if ({sif.din_ready, ready, len, err_char, overflow, rd_oob_a, rd_data_a, rd_oob_b, rd_data_b} !== '0) begin
         n_err++;
         $display("FAIL reset_main got dr=%b rdy=%b len=%0d err=%b ovf=%b oa=%b da=%h ob=%b db=%h want all 0",
                  sif.din_ready, ready, len, err_char, overflow, rd_oob_a, rd_data_a, rd_oob_b, rd_data_b);
      end
      n_vec++;
      if ({sif4.din_ready, ready4, len4, err4, ovf4, rd_oob_a4, rd_data_a4, rd_oob_b4, rd_data_b4} !== '0) begin
         n_err++;
         $display("FAIL reset_small got dr=%b rdy=%b len=%0d ovf=%b want all 0", sif4.din_ready, ready4, len4, ovf4);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_ctgat();
      pulse_start();
      send("CTGAT");
      pulse_done();
      n_vec++;
      if ({len, ready, err_char} !== {8'd5, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL ctgat_status got len=%0d rdy=%b err=%b want len=5 rdy=1 err=0", len, ready, err_char);
      end
      for (int i = 0; i < 5; i++) rd(1'b1, 7'(i), 1'b0, 7'd0);
   endtask

   task automatic test_dual_read();
      rd(1'b1, 7'd2, 1'b1, 7'd7);
      rd_addr_a = 7'd0; rd_addr_b = 7'd1;
      tick();
      tick();
      n_vec++;
      if ({rd_oob_a, rd_data_a, rd_oob_b, rd_data_b} !== {last_a, last_b}) begin
         n_err++;
         $display("FAIL dual_hold got a=%b/%h b=%b/%h want a=%b/%h b=%b/%h", rd_oob_a, rd_data_a, rd_oob_b, rd_data_b,
                  last_a[8], last_a[7:0], last_b[8], last_b[7:0]);
      end
   endtask

   task automatic test_normalise();
      pulse_start();
      send("acgX");
      pulse_done();
      n_vec++;
      if ({len, ready, err_char} !== {8'd4, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL norm_status got len=%0d rdy=%b err=%b want len=4 rdy=1 err=1", len, ready, err_char);
      end
      for (int i = 0; i < 4; i++) rd(1'b1, 7'(i), 1'b1, 7'(3 - i));
      pulse_start();
      n_vec++;
      if ({err_char, ready, len, sif.din_ready} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
         n_err++;
         $display("FAIL norm_clear got err=%b rdy=%b len=%0d dr=%b want err=0 rdy=0 len=0 dr=1", err_char, ready, len, sif.din_ready);
      end
      rd(1'b1, 7'd0, 1'b1, 7'd1);
   endtask

   task automatic test_done_with_data();
      pulse_start();
      send("GA");
      sif.din = "T"; sif.din_valid = 1'b1; sif.load_done = 1'b1;
      tick();
      sif.din_valid = 1'b0; sif.load_done = 1'b0;
      model[m_wp] = tb_norm("T"); m_wp++; m_len = m_wp; m_ready = 1;
      n_vec++;
      if ({len, ready} !== {8'd3, 1'b1}) begin
         n_err++;
         $display("FAIL done_same_cycle got len=%0d rdy=%b want len=3 rdy=1", len, ready);
      end
      rd(1'b1, 7'd2, 1'b1, 7'd3);
      pulse_start();
      pulse_done();
      n_vec++;
      if ({len, ready} !== {8'd0, 1'b1}) begin
         n_err++;
         $display("FAIL empty_load got len=%0d rdy=%b want len=0 rdy=1", len, ready);
      end
      rd(1'b1, 7'd0, 1'b1, 7'd0);
      rd(1'b1, 7'd1, 1'b1, 7'd127);
      sif.load_start = 1'b1; sif.load_done = 1'b1;
      tick();
      sif.load_start = 1'b0; sif.load_done = 1'b0;
      m_wp = 0; m_len = 0; m_ready = 0;
      n_vec++;
      if ({ready, sif.din_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL start_wins got rdy=%b dr=%b want rdy=0 dr=1", ready, sif.din_ready);
      end
   endtask

   task automatic test_overflow();
      string s;
      logic [7:0] got;
      s = "ACGTC";
      sif4.load_start = 1'b1;
      tick();
      sif4.load_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if (sif4.din_ready !== (i < 4)) begin
            n_err++;
            $display("FAIL ovf_din_ready char=%0d got %b want %b", i, sif4.din_ready, (i < 4));
         end
         sif4.din = s[i]; sif4.din_valid = 1'b1;
         tick();
      end
      sif4.din_valid = 1'b0;
      n_vec++;
      if (ovf4 !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_flag got %b want 1", ovf4);
      end
      sif4.load_done = 1'b1;
      tick();
      sif4.load_done = 1'b0;
      n_vec++;
      if ({len4, ready4, ovf4, err4} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL ovf_status got len=%0d rdy=%b ovf=%b err=%b want len=4 rdy=1 ovf=1 err=0", len4, ready4, ovf4, err4);
      end
      rd_en_a4 = 1'b1; rd_addr_a4 = 2'd3;
      q_a.push_back({1'b0, 8'h54});
      tick();
      rd_en_a4 = 1'b0;
      got = rd_data_a4;
      n_vec++;
      if ({rd_oob_a4, got} !== q_a.pop_front()) begin
         n_err++;
         $display("FAIL ovf_last_char got oob=%b data=%h want oob=0 data=54", rd_oob_a4, got);
      end
   endtask

   task automatic test_async_reset();
      pulse_start();
      send("AC");
      rd(1'b1, 7'd0, 1'b1, 7'd1);
      #3 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({sif.din_ready, ready, len, err_char, overflow, rd_oob_a, rd_data_a, rd_oob_b, rd_data_b} !== '0) begin
         n_err++;
         $display("FAIL async_reset got dr=%b rdy=%b len=%0d oa=%b ob=%b want all 0", sif.din_ready, ready, len, rd_oob_a, rd_oob_b);
      end
      rst_n = 1'b1;
      m_wp = 0; m_len = 0; m_ready = 0;
      sif.din = "G"; sif.din_valid = 1'b1;
      tick();
      sif.din_valid = 1'b0;
      n_vec++;
      if ({sif.din_ready, ready, err_char, overflow, len} !== '0) begin
         n_err++;
         $display("FAIL idle_ignore got dr=%b rdy=%b err=%b ovf=%b len=%0d want all 0", sif.din_ready, ready, err_char, overflow, len);
      end
      pulse_start();
      send("GT");
      pulse_done();
      n_vec++;
      if ({len, ready} !== {8'd2, 1'b1}) begin
         n_err++;
         $display("FAIL reload_status got len=%0d rdy=%b want len=2 rdy=1", len, ready);
      end
      rd(1'b1, 7'd0, 1'b1, 7'd1);
      rd(1'b1, 7'd1, 1'b1, 7'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.load_start = 0; sif.din = 0; sif.din_valid = 0; sif.load_done = 0;
      sif4.load_start = 0; sif4.din = 0; sif4.din_valid = 0; sif4.load_done = 0;
      test_reset();
      test_ctgat();
      test_dual_read();
      test_normalise();
      test_done_with_data();
      test_overflow();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_buffer.md
Name: seq_buffer

Overview:
- Parametrised sequence store for the NW aligner; replaces the hard-initialised test RAMs.
- Loads one nucleotide sequence through a valid/ready stream and normalises each character to upper-case ACGT, or N when invalid.
- Records the sequence length and exposes two independent registered read ports: port A for matrix fill, port B for traceback.
- One instance each for sequence A and sequence B.

Parameters:
- DEPTH, 128, maximum sequence length in characters
- AW, $clog2(DEPTH), address width
- LW, $clog2(DEPTH+1), length width (must represent DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- load_start  in  1  pulse: begin (re)loading a sequence
- din  in  8  ASCII character
- din_valid  in  1  din is presented
- din_ready  out  1  block accepts din this cycle
- load_done  in  1  pulse: sequence complete
- ready  out  1  sequence loaded and readable
- len  out  LW  number of stored characters
- err_char  out  1  sticky: an invalid character was received in the current load
- overflow  out  1  sticky: a character was offered while the buffer was full
- rd_en_a  in  1  port A read enable
- rd_addr_a  in  AW  port A address
- rd_data_a  out  8  port A data
- rd_oob_a  out  1  port A address invalid (registered with data)
- rd_en_b  in  1  port B read enable
- rd_addr_b  in  AW  port B address
- rd_data_b  out  8  port B data
- rd_oob_b  out  1  port B address invalid (registered with data)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; wptr=0.
  - din_ready, ready, len, err_char, overflow, rd_data_*, rd_oob_* all 0.
  - Memory contents are not reset.
- FSM states IDLE, LOAD, READY:
  - IDLE: din_ready=0. load_start -> LOAD.
  - LOAD: din_ready = (wptr<DEPTH). load_done -> READY, with len<=wptr (the count including any write in the same cycle).
  - READY: ready=1. load_start -> LOAD.
- Entering LOAD (from IDLE or READY) clears wptr, len, err_char, overflow and ready in the same edge.
- load_start while already in LOAD restarts the load: wptr=0, flags cleared.
- If load_start and load_done are asserted together, load_start wins.
- Write accept = din_valid & din_ready: mem[wptr]<=norm(din), wptr<=wptr+1.
- norm(din):
  - A/C/G/T map to themselves; a/c/g/t map to upper case.
  - Any other byte -> 8'h4E ('N'), and err_char is set.
- Full condition: wptr==DEPTH in LOAD forces din_ready=0. din_valid in that state sets overflow; the data is dropped and wptr holds.
- load_done with din_valid in the same cycle: the character is written and counted, then the FSM moves to READY.
- load_done with zero characters accepted -> READY, len=0.
- din_valid outside LOAD is ignored; no flag is set.
- Read ports:
  - 1-cycle latency; each port is independent; both may read the same address in the same cycle.
  - rd_en high: rd_data <= mem[addr] and rd_oob <= (state!=READY) | (addr>=len).
  - When oob, rd_data <= 0.
  - rd_en low: rd_data and rd_oob hold their previous values.
- Read and write collision: a read issued in LOAD is always oob, so no read-during-write hazard is visible.
- Reset mid-load: everything returns to IDLE with len=0. The stored data is considered invalid until the next load completes.

Decomposition:
- nw_pkg holds:
  - ASCII constants CH_A=8'h41, CH_C=8'h43, CH_G=8'h47, CH_T=8'h54, CH_N=8'h4E;
  - state encoding for IDLE/LOAD/READY;
  - the normalisation function, shared with the scoring unit.
- One sub-module, seq_mem_2r1w: DEPTH x 8 array, one synchronous write port, two synchronous read ports with enables. No reset on the array.
- FSM, pointer, length and flags stay in seq_buffer.

Test Plan:
- Reset, load_start, then stream "CTGAT" with one din_valid per cycle, then load_done -> len=5, ready=1, err_char=0. Reading addr 0..4 on port A returns 43,54,47,41,54, one cycle after each rd_en.
- Stream "acgX" -> stored 41,43,47,4E; err_char=1; len=4. A following load_start clears err_char to 0.
- DEPTH=4: offer 5 characters -> din_ready drops after the 4th, overflow=1, len=4. Address 3 holds the 4th character, not the 5th.
- In READY with len=5: port A reads addr 2 while port B reads addr 7 in the same cycle -> rd_data_a=47/rd_oob_a=0, rd_data_b=00/rd_oob_b=1. Both outputs hold while rd_en is low.
- load_done in the same cycle as the 3rd din_valid -> len=3, ready=1. An immediate load_done with zero characters on a fresh load -> len=0, and every read is oob.
- Assert rst=0 asynchronously mid-load after 2 characters -> all outputs 0 immediately. A new load of "GT" gives len=2 and reads 47,54.
